// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// serial_pkg : shared types and defaults for the parallel-to-serial block
// Revision   : 1.0
// ============================================================================
package serial_pkg;

  localparam int unsigned DEFAULT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/contador_bits.sv
`default_nettype none
// ============================================================================
// contador_bits : bit counter with synchronous clear, enable and terminal flag
// Revision      : 1.0
// ============================================================================
module contador_bits #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned TERMINAL = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] C_TERM = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q, count_d;

  // Saturates instead of wrapping so a stray enable can never alias tc.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != C_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == C_TERM);

endmodule
`default_nettype wire

// File: rtl/serializador_ps.sv
`default_nettype none
// ============================================================================
// serializador_ps : parallel-in / serial-out framer with optional even parity
// Revision        : 1.0
// ============================================================================
module serializador_ps
  import serial_pkg::*;
#(
  parameter int unsigned BITS      = DEFAULT_BITS,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] Din,
  input  logic            valid,
  input  logic            hold,
  output logic            ready,
  output logic            Dout,
  output logic            dout_valid,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CNT_W = $clog2(BITS + 1);

  state_t          state_q, state_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic            parity_q, parity_d;
  logic [BITS-1:0] shreg_shifted;
  logic            head_bit;
  logic            cnt_clr, cnt_en, cnt_tc;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_bit      = shreg_q[BITS-1];
      assign shreg_shifted = {shreg_q[BITS-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_bit      = shreg_q[0];
      assign shreg_shifted = {1'b0, shreg_q[BITS-1:1]};
    end
  endgenerate

  contador_bits #(
    .WIDTH    (CNT_W),
    .TERMINAL (BITS - 1)
  ) u_contador (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          shreg_d  = Din;
          parity_d = ^Din;
          cnt_clr  = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          shreg_d = shreg_shifted;
          cnt_en  = 1'b1;
          if (cnt_tc) begin
            state_d = PARITY_EN ? PARITY : DONE;
          end
        end
      end
      PARITY: begin
        if (!hold) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
    end
  end

  // Dout follows the frozen register contents, so a held bit stays on the line.
  always_comb begin
    Dout = 1'b0;
    case (state_q)
      SHIFT:   Dout = head_bit;
      PARITY:  Dout = parity_q;
      default: Dout = 1'b0;
    endcase
  end

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q == SHIFT) || (state_q == PARITY);
  assign done       = (state_q == DONE);
  assign dout_valid = busy && !hold;

endmodule
`default_nettype wire
